rob_wb_arbiter: RTL and testbench

Writeback arbiter between the execution units and the reorder buffer's 4 writeback ports. Up to NUM_REQ functional-unit results compete each cycle. The arbiter grants at most NUM_WB of them under round-robin fairness and registers the winners onto the ROB writeback bus. Results younger than a mispredicted branch are squashed in flight.

---
 rtl/rob_pkg.sv | 26 ++
 rtl/wb_rr_picker.sv | 44 ++++
 rtl/rob_wb_arbiter.sv | 136 +++++++++++++
 tb/tb_rob_wb_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared ROB definitions: geometry, writeback word layout and the
// circular age helper used to order tags relative to the commit pointer.
package rob_pkg;

  localparam int ROB_DEPTH = 64;
  localparam int TAG_W     = 7;
  localparam int WB_PORTS  = 4;
  localparam int AGE_W     = $clog2(ROB_DEPTH);
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [WB_DATA_W-1:0] data;
  } wb_word_t;

  // Distance of a tag from the commit pointer around the 64-entry ring.
  // A larger age means the instruction is younger.
  function automatic logic [AGE_W-1:0] rob_age(input logic [TAG_W-1:0] tag,
                                               input logic [TAG_W-1:0] head);
    logic [TAG_W-1:0] diff;
    diff = tag - head;
    return diff[AGE_W-1:0];
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin picker: scans the request mask starting at rr_ptr and hands
// out up to NUM_WB one-hot grants in scan order, plus the next pointer.
// Purely combinational.
module wb_rr_picker #(
  parameter int NUM_REQ = 6,
  parameter int NUM_WB  = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]             req_mask_i,
  input  logic [PTR_W-1:0]               rr_ptr_i,
  output logic [NUM_WB-1:0][NUM_REQ-1:0] grant_oh_o,
  output logic [NUM_WB-1:0]              grant_vld_o,
  output logic [PTR_W-1:0]               rr_ptr_next_o
);

  // Walk requesters in rotated order; the k-th winner lands on port k and
  // the pointer moves just past the last winner (unchanged if none).
  always_comb begin
    int cnt;
    int pos;
    grant_oh_o    = '0;
    grant_vld_o   = '0;
    rr_ptr_next_o = rr_ptr_i;
    cnt           = 0;
    pos           = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == pos && req_mask_i[j] && cnt < NUM_WB) begin
          for (int p = 0; p < NUM_WB; p++) begin
            if (p == cnt) begin
              grant_oh_o[p][j] = 1'b1;
              grant_vld_o[p]   = 1'b1;
            end
          end
          rr_ptr_next_o = (j == NUM_REQ - 1) ? '0 : PTR_W'(j + 1);
          cnt = cnt + 1;
        end
      end
    end
  end

endmodule

// File: rtl/rob_wb_arbiter.sv
// ROB writeback arbiter: squashes results younger than a mispredicted
// branch, grants up to NUM_WB survivors round-robin and registers them onto
// the ROB writeback ports. A global stall freezes all state.
module rob_wb_arbiter #(
  parameter int NUM_REQ = 6,
  parameter int NUM_WB  = 4,
  parameter int TAG_W   = 7,
  parameter int DATA_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stop,
  input  logic [NUM_REQ-1:0]    fu_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  fu_tag,
  input  logic [NUM_REQ*DATA_W-1:0] fu_data,
  output logic [NUM_REQ-1:0]    fu_ready,
  input  logic                  flush,
  input  logic [TAG_W-1:0]      flush_tag,
  input  logic [TAG_W-1:0]      rob_head,
  output logic [NUM_WB-1:0]     wb_valid,
  output logic [NUM_WB*8-1:0]   wb_tag,
  output logic [NUM_WB*DATA_W-1:0] wb_data,
  output logic [15:0]           drop_cnt
);

  import rob_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);

  logic                             active;
  logic [NUM_REQ-1:0]               younger;
  logic [NUM_REQ-1:0]               squash;
  logic [NUM_REQ-1:0]               req_mask;
  logic [NUM_REQ-1:0]               granted;
  logic [NUM_WB-1:0][NUM_REQ-1:0]   grant_oh;
  logic [NUM_WB-1:0]                grant_vld;
  logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [15:0]                      drop_cnt_q, drop_cnt_d;
  logic [NUM_WB-1:0]                wb_valid_q;
  logic [3:0]                       sq_count;
  logic [16:0]                      drop_sum;

  // Nothing is accepted while stalled or held in reset.
  assign active = ~stop & ~reset;

  genvar gi, gj;

  // Per-requester age compare: squash the younger ones, offer the rest.
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic [TAG_W-1:0]  tag_g;
    logic [NUM_WB-1:0] col;
    assign tag_g         = fu_tag[gi*TAG_W +: TAG_W];
    assign younger[gi]   = flush && (rob_age(tag_g, rob_head) > rob_age(flush_tag, rob_head));
    assign squash[gi]    = active & fu_valid[gi] & younger[gi];
    assign req_mask[gi]  = active & fu_valid[gi] & ~younger[gi];
    for (gj = 0; gj < NUM_WB; gj++) begin : g_col
      assign col[gj] = grant_oh[gj][gi];
    end
    assign granted[gi] = |col;
  end

  assign fu_ready = granted | squash;

  wb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .NUM_WB  (NUM_WB),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_mask_i    (req_mask),
    .rr_ptr_i      (rr_ptr_q),
    .grant_oh_o    (grant_oh),
    .grant_vld_o   (grant_vld),
    .rr_ptr_next_o (rr_ptr_d)
  );

  // Count this cycle's squashes and add them to the drop counter, saturating.
  always_comb begin
    sq_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sq_count = sq_count + 4'(squash[i]);
    end
    drop_sum   = {1'b0, drop_cnt_q} + 17'(sq_count);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Pointer, drop counter and port valids advance only on unstalled edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      drop_cnt_q <= '0;
      wb_valid_q <= '0;
    end else if (!stop) begin
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      wb_valid_q <= grant_vld;
    end
  end

  // Per-port data path: mux the granted requester, load only when used.
  for (gi = 0; gi < NUM_WB; gi++) begin : g_port
    logic [7:0]        tag_mux;
    logic [DATA_W-1:0] data_mux;
    logic [7:0]        tag_q;
    logic [DATA_W-1:0] data_q;

    // One-hot select of the requester granted onto this port.
    always_comb begin
      tag_mux  = '0;
      data_mux = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_oh[gi][i]) begin
          tag_mux  = tag_mux | 8'(fu_tag[i*TAG_W +: TAG_W]);
          data_mux = data_mux | fu_data[i*DATA_W +: DATA_W];
        end
      end
    end

    // Unused ports keep their previous tag/data so the bus toggles less.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tag_q  <= '0;
        data_q <= '0;
      end else if (!stop && grant_vld[gi]) begin
        tag_q  <= tag_mux;
        data_q <= data_mux;
      end
    end

    assign wb_tag[gi*8 +: 8]          = tag_q;
    assign wb_data[gi*DATA_W +: DATA_W] = data_q;
  end

  assign wb_valid = wb_valid_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Scoreboard bench for rob_wb_arbiter: the driver computes the expected
// accept mask and writeback word from the age/round-robin rules and queues
// the word; an independent monitor pops and compares every loaded word.
module tb_rob_wb_arbiter;
  import rob_pkg::*;

  localparam int NR = 6;
  localparam int NW = 4;
  localparam int TW = 7;
  localparam int DW = 32;

  typedef struct packed {
    logic [NW-1:0]           mask;
    wb_word_t [NW-1:0]       port;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset, stop, flush;
  logic [NR-1:0]     fu_valid;
  logic [NR*TW-1:0]  fu_tag;
  logic [NR*DW-1:0]  fu_data;
  logic [NR-1:0]     fu_ready;
  logic [TW-1:0]     flush_tag, rob_head;
  logic [NW-1:0]     wb_valid;
  logic [NW*8-1:0]   wb_tag;
  logic [NW*DW-1:0]  wb_data;
  logic [15:0]       drop_cnt;

  rob_wb_arbiter #(.NUM_REQ(NR), .NUM_WB(NW), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .stop(stop),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data), .fu_ready(fu_ready),
    .flush(flush), .flush_tag(flush_tag), .rob_head(rob_head),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            m_ptr, m_drop;
  logic [NR-1:0] exp_ready;
  exp_t          exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int age(input int t, input int h);
    return (t - h) & 63;
  endfunction

  // One cycle: model the accept/grant decision, check fu_ready and
  // drop_cnt, queue the expected word, then cross the clock edge.
  task automatic step();
    int   order[$];
    int   n;
    logic [NR-1:0] sq, gr;
    exp_t e;
    sq = '0; gr = '0; e = '0; n = 0;
    if (!reset && !stop) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (fu_valid[i]) begin
          if (flush && age(int'(fu_tag[i*TW +: TW]), int'(rob_head)) > age(int'(flush_tag), int'(rob_head)))
            sq[i] = 1'b1;
          else
            order.push_back(i);
        end
      end
      n = (order.size() < NW) ? order.size() : NW;
      for (int p = 0; p < n; p++) begin
        gr[order[p]]      = 1'b1;
        e.mask[p]         = 1'b1;
        e.port[p].valid   = 1'b1;
        e.port[p].tag     = fu_tag[order[p]*TW +: TW];
        e.port[p].data    = fu_data[order[p]*DW +: DW];
      end
    end
    exp_ready = sq | gr;
    #1;
    check("fu_ready", 64'(fu_ready), 64'(exp_ready));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (!reset && !stop) begin
      m_drop = m_drop + $countones(sq);
      if (m_drop > 65535) m_drop = 65535;
      if (n > 0) begin
        m_ptr = (order[n-1] + 1) % NR;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_fu(input int i, input int tag, input logic [31:0] data);
    fu_valid[i]       = 1'b1;
    fu_tag[i*TW +: TW] = TW'(tag);
    fu_data[i*DW +: DW] = data;
  endtask

  // Monitor: every word loaded on an unstalled edge is popped and compared.
  initial begin
    logic s, r;
    exp_t e;
    forever begin
      @(posedge clk);
      s = stop;
      r = reset;
      #1;
      if (!s && !r && wb_valid != '0) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wb_unexpected: got valid=%b expected no word", wb_valid);
        end else begin
          e = exp_q.pop_front();
          check("wb_valid", 64'(wb_valid), 64'(e.mask));
          for (int p = 0; p < NW; p++) begin
            if (e.mask[p]) begin
              check("wb_tag", 64'(wb_tag[p*8 +: 8]), 64'({1'b0, e.port[p].tag}));
              check("wb_data", 64'(wb_data[p*DW +: DW]), 64'(e.port[p].data));
            end
          end
          $display("[TB] wb valid=%b tag=%h data=%h", wb_valid, wb_tag, wb_data);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stop = 1'b0; flush = 1'b0;
    fu_valid = '0; fu_tag = '0; fu_data = '0;
    flush_tag = '0; rob_head = '0;
    m_ptr = 0; m_drop = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_tag", 64'(wb_tag), 64'd0);
    check("rst_wb_data_lo", wb_data[63:0], 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_ready", 64'(fu_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Six requesters, tags 0..5: two cycles to drain
    for (int i = 0; i < NR; i++) set_fu(i, i, 32'h100 + i);
    step();
    check("t1_wb_tag", 64'(wb_tag), 64'h03020100);
    fu_valid &= ~exp_ready;
    step();
    check("t1b_wb_valid", 64'(wb_valid), 64'b0011);
    check("t1b_wb_tag", 64'(wb_tag[15:0]), 64'h0504);
    fu_valid &= ~exp_ready;

    // Single requester FU5
    set_fu(5, 9, 32'hDEAD);
    step();
    check("t2_wb_valid", 64'(wb_valid), 64'b0001);
    check("t2_wb_data", 64'(wb_data[31:0]), 64'hDEAD);
    fu_valid &= ~exp_ready;

    // Mispredict squash with wrapped ages
    rob_head = 7'd60; flush = 1'b1; flush_tag = 7'd62;
    set_fu(0, 63, 32'hA0); set_fu(1, 1, 32'hA1);
    set_fu(2, 61, 32'hA2); set_fu(3, 62, 32'hA3);
    step();
    check("t3_wb_valid", 64'(wb_valid), 64'b0011);
    check("t3_wb_tag", 64'(wb_tag[15:0]), 64'h3E3D);
    fu_valid &= ~exp_ready;
    flush = 1'b0;
    check("t3_drop", 64'(drop_cnt), 64'd2);

    // Stall holds the loaded word
    set_fu(0, 7, 32'hC0DE0007);
    step();
    fu_valid &= ~exp_ready;
    set_fu(1, 8, 32'hC0DE0008);
    stop = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t4_hold_valid", 64'(wb_valid), 64'b0001);
      check("t4_hold_tag", 64'(wb_tag[7:0]), 64'd7);
      check("t4_hold_data", 64'(wb_data[31:0]), 64'hC0DE0007);
    end
    stop = 1'b0;
    step();
    check("t4_next_tag", 64'(wb_tag[7:0]), 64'd8);
    fu_valid &= ~exp_ready;

    // Asynchronous reset mid-stream
    for (int i = 0; i < NR; i++) set_fu(i, 20 + i, 32'h2000 + i);
    step();
    check("t5_full", 64'(wb_valid), 64'b1111);
    fu_valid &= ~exp_ready;
    reset = 1'b1;
    #1;
    check("t5_rst_valid", 64'(wb_valid), 64'd0);
    check("t5_rst_tag", 64'(wb_tag), 64'd0);
    check("t5_rst_data", wb_data[63:0], 64'd0);
    check("t5_rst_drop", 64'(drop_cnt), 64'd0);
    m_ptr = 0; m_drop = 0;
    step();
    reset = 1'b0;
    for (int i = 2; i < NR; i++) set_fu(i, 30 + i, 32'h3000 + i);
    step();
    check("t5_first_fu0", 64'(wb_tag[7:0]), 64'd20);
    fu_valid &= ~exp_ready;

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      stop      = ($urandom_range(0, 99) < 15);
      flush     = ($urandom_range(0, 99) < 25);
      flush_tag = TW'($urandom);
      rob_head  = TW'($urandom);
      for (int i = 0; i < NR; i++)
        if (!fu_valid[i] && $urandom_range(0, 99) < 60)
          set_fu(i, int'($urandom_range(0, 127)), $urandom);
      step();
      fu_valid &= ~exp_ready;
    end
    stop = 1'b0; flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      fu_valid &= ~exp_ready;
    end
    fu_valid = '0;

    // Drive the drop counter to 0xFFFE through real squashes, then saturate
    flush = 1'b1; rob_head = 7'd0; flush_tag = 7'd0;
    for (int i = 0; i < NR; i++) set_fu(i, i + 1, 32'h0);
    while (m_drop + NR <= 16'hFFFE) step();
    fu_valid = NR'((1 << (16'hFFFE - m_drop)) - 1);
    step();
    fu_valid = '0;
    step();
    check("sat_fffe", 64'(drop_cnt), 64'hFFFE);
    fu_valid = 6'b000111;
    step();
    fu_valid = '0;
    step();
    check("sat_ffff", 64'(drop_cnt), 64'hFFFF);
    fu_valid = '1;
    step();
    fu_valid = '0;
    step();
    check("sat_hold", 64'(drop_cnt), 64'hFFFF);
    flush = 1'b0;

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
